// File: rtl/ps2_direction_decoder.sv
// ps2_direction_decoder
// Deframes raw PS/2 keyboard traffic and turns the arrow keys and the space
// bar into held-key controls for the player plane: a one-hot direction
// request and a fire level.
// Optional feature macro: PS2_PARITY_CHECK_EN. When it is defined, odd parity
// is enforced on every frame. When it is undefined, the parity bit is
// ignored.
module ps2_direction_decoder #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] direction,
    output logic       fire,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TIME_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

    frame_state_t    state_q, state_d;
    logic            clk_s1, clk_s2, data_s1, data_s2;
    logic            clk_level;
    logic [FW-1:0]   filt_cnt;
    logic            strobe;
    logic [TW-1:0]   timeout_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            parity_ok;
    logic            accept, reject, timeout_hit;
    logic            ext, brk;
    logic [3:0]      held;
    logic [3:0]      arrow;
    logic            is_space;
    logic [3:0]      remaining;
    logic [3:0]      next_last;

    // Two-flop synchronizers; idle-high reset values prevent a fake edge after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    // Glitch filter: the level flips only after FILTER_LEN consecutive disagreeing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_level <= 1'b1;
            filt_cnt  <= '0;
        end else if (clk_s2 == clk_level) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FILT_LAST) begin
            clk_level <= clk_s2;
            filt_cnt  <= '0;
        end else begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    // The bit strobe is the cycle in which the filtered clock is about to fall
    assign strobe = clk_level && !clk_s2 && (filt_cnt == FILT_LAST);

`ifdef PS2_PARITY_CHECK_EN
    logic parity_bit;

    // Capture the parity bit so that odd parity can be judged in STOP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_bit <= 1'b0;
        end else if (strobe && state_q == PARITY) begin
            parity_bit <= data_s2;
        end
    end

    assign parity_ok = ^{shift, parity_bit};
`else
    assign parity_ok = 1'b1;
`endif

    // Frame state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame sequencing: a stall abandons the frame, otherwise advance once per strobe
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        reject      = 1'b0;
        timeout_hit = 1'b0;
        if (state_q != IDLE && !strobe && timeout_cnt == TIME_LAST) begin
            timeout_hit = 1'b1;
            state_d     = IDLE;
        end else if (strobe) begin
            case (state_q)
                IDLE:    if (!data_s2) state_d = DATA;
                DATA:    if (bit_cnt == 3'd7) state_d = PARITY;
                PARITY:  state_d = STOP;
                STOP: begin
                    state_d = IDLE;
                    if (data_s2 && parity_ok) begin
                        accept = 1'b1;
                    end else begin
                        reject = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Stall counter: cleared by every strobe, runs only while a frame is open
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_cnt <= '0;
        end else if (strobe || state_q == IDLE || timeout_hit) begin
            timeout_cnt <= '0;
        end else begin
            timeout_cnt <= timeout_cnt + TW'(1);
        end
    end

    // Shift the data bits in LSB first and count them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            shift   <= '0;
        end else if (strobe) begin
            if (state_q == IDLE) begin
                bit_cnt <= '0;
            end else if (state_q == DATA) begin
                shift   <= {data_s2, shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // Publish accepted bytes and report rejected or abandoned frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code       <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            code_valid <= accept;
            frame_err  <= reject | timeout_hit;
            if (accept) begin
                code <= shift;
            end
        end
    end

    // Map the current byte onto an arrow bit or the space key
    always_comb begin
        arrow    = 4'b0000;
        is_space = 1'b0;
        if (ext) begin
            case (code)
                8'h75:   arrow = 4'b0001;
                8'h72:   arrow = 4'b0010;
                8'h6B:   arrow = 4'b0100;
                8'h74:   arrow = 4'b1000;
                default: arrow = 4'b0000;
            endcase
        end else if (code == 8'h29) begin
            is_space = 1'b1;
        end
        remaining = held & ~arrow;
        next_last = remaining & (~remaining + 4'd1);
    end

    // Decoder: the prefix flags and held-key tracking; direction doubles as the last-pressed arrow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext       <= 1'b0;
            brk       <= 1'b0;
            held      <= '0;
            direction <= '0;
            fire      <= 1'b0;
        end else if (code_valid) begin
            if (code == 8'hE0) begin
                ext <= 1'b1;
            end else if (code == 8'hF0) begin
                brk <= 1'b1;
            end else begin
                ext <= 1'b0;
                brk <= 1'b0;
                if (arrow != 4'b0000) begin
                    if (!brk) begin
                        held      <= held | arrow;
                        direction <= arrow;
                    end else begin
                        held <= remaining;
                        if (direction == arrow) begin
                            direction <= next_last;
                        end
                    end
                end
                if (is_space) begin
                    fire <= !brk;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Testbench for ps2_direction_decoder: directed frames from the test plan,
// then randomized keyboard traffic against a key-state reference model.
// Expected responses are queued and checked by an independent monitor.
module tb_ps2_direction_decoder;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 100;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        logic [3:0] dir;
        logic       fire;
        bit         chk_time;
        int         lo;
        int         hi;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [3:0] direction;
    logic       fire;
    logic [7:0] code;
    logic       code_valid;
    logic       frame_err;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_fall = 0;
    bit   dir_due = 0;

    // Reference key state
    bit   m_ext, m_brk, m_fire;
    bit   m_held[4];
    int   m_last;

    ps2_direction_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .direction(direction), .fire(fire), .code(code),
        .code_valid(code_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Cycle counter for latency checks
    always @(posedge clk) cyc = cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [3:0] model_dir();
        return (m_last < 0) ? 4'b0000 : 4'(1 << m_last);
    endfunction

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_fire = 0; m_last = -1;
        for (int i = 0; i < 4; i++) m_held[i] = 0;
    endtask

    // Behavioural key model: arrows are tracked as a set plus a last-pressed index
    task automatic model_byte(input logic [7:0] b);
        int idx;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            idx = -1;
            if (m_ext) begin
                if (b == 8'h75) idx = 0;
                if (b == 8'h72) idx = 1;
                if (b == 8'h6B) idx = 2;
                if (b == 8'h74) idx = 3;
            end
            if (idx >= 0) begin
                if (!m_brk) begin
                    m_held[idx] = 1;
                    m_last = idx;
                end else begin
                    m_held[idx] = 0;
                    if (m_last == idx) begin
                        m_last = -1;
                        for (int j = 0; j < 4; j++) if (m_held[j] && m_last < 0) m_last = j;
                    end
                end
            end
            if (!m_ext && b == 8'h29) m_fire = !m_brk;
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic drive_bit(input logic b, input int half);
        @(negedge clk);
        ps2_data = b;
        repeat (half) @(negedge clk);
        ps2_clk = 1'b0;
        last_fall = cyc;
        repeat (half) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // Queue the expected response for one frame, then drive it onto the pins
    task automatic apply_stimulus(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int half);
        exp_t e;
        bit   ok;
        logic par;
        ok = !bad_stop && (!PAR_ON || !bad_par);
        e = '{is_err: !ok, code: b, dir: 4'b0, fire: 1'b0, chk_time: 0, lo: 0, hi: 0};
        if (ok) model_byte(b);
        e.dir  = model_dir();
        e.fire = m_fire;
        exp_q.push_back(e);
        par = (~^b) ^ bad_par;
        drive_bit(1'b0, half);
        for (int i = 0; i < 8; i++) drive_bit(b[i], half);
        drive_bit(par, half);
        drive_bit(!bad_stop, half);
        ps2_data = 1'b1;
        repeat (2 * half) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && !dir_due) break;
            @(negedge clk);
        end
        check_output("queue_drained", exp_q.size(), 0);
    endtask

    // Monitor: pops an expectation per code_valid/frame_err pulse, checks direction/fire a cycle later
    initial begin
        exp_t cur;
        exp_t due;
        logic [3:0] prev_dir = 0;
        logic prev_fire = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                dir_due = 0;
                prev_dir = 0;
                prev_fire = 0;
            end else begin
                if (code_valid && frame_err) check_output("valid_err_overlap", 1, 0);
                if (dir_due) begin
                    check_output("direction", direction, due.dir);
                    check_output("fire", fire, due.fire);
                    dir_due = 0;
                end else if (direction !== prev_dir || fire !== prev_fire) begin
                    check_output("spurious_output_change", {direction, 3'b0, fire}, {prev_dir, 3'b0, prev_fire});
                end
                prev_dir = direction;
                prev_fire = fire;
                if (code_valid || frame_err) begin
                    if (exp_q.size() == 0) begin
                        check_output("unexpected_pulse", {code_valid, frame_err}, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        check_output("pulse_kind", frame_err, cur.is_err);
                        if (code_valid) begin
                            check_output("code", code, cur.code);
                            due = cur;
                            dir_due = 1;
                        end
                        if (cur.chk_time) begin
                            n_cmp++;
                            if (cyc < cur.lo || cyc > cur.hi) begin
                                n_err++;
                                $display("[TB] FAIL timeout_latency: got cycle %0d expected %0d..%0d", cyc, cur.lo, cur.hi);
                            end
                        end
                    end
                end
            end
        end
    end

    // Global guard so the run always ends
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d expectations pending", exp_q.size());
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] picks[7];
        logic [7:0] b;
        exp_t e;
        picks = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h29};
        model_reset();
        repeat (4) @(negedge clk);
        check_output("reset_direction", direction, 0);
        check_output("reset_fire", fire, 0);
        check_output("reset_code", code, 0);
        check_output("reset_code_valid", code_valid, 0);
        check_output("reset_frame_err", frame_err, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        $display("[TB] arrow make/break");
        apply_stimulus(8'hE0, 0, 0, 20);
        apply_stimulus(8'h75, 0, 0, 20);
        drain();
        check_output("up_code", code, 8'h75);
        check_output("up_direction", direction, 4'b0001);
        apply_stimulus(8'hE0, 0, 0, 20);
        apply_stimulus(8'hF0, 0, 0, 20);
        apply_stimulus(8'h75, 0, 0, 20);
        drain();
        check_output("up_break_direction", direction, 4'b0000);

        $display("[TB] left/right overlap");
        apply_stimulus(8'hE0, 0, 0, 18);
        apply_stimulus(8'h6B, 0, 0, 18);
        apply_stimulus(8'hE0, 0, 0, 18);
        apply_stimulus(8'h74, 0, 0, 18);
        drain();
        check_output("right_over_left", direction, 4'b1000);
        apply_stimulus(8'hE0, 0, 0, 18);
        apply_stimulus(8'hF0, 0, 0, 18);
        apply_stimulus(8'h74, 0, 0, 18);
        drain();
        check_output("back_to_left", direction, 4'b0100);
        apply_stimulus(8'hE0, 0, 0, 18);
        apply_stimulus(8'hF0, 0, 0, 18);
        apply_stimulus(8'h6B, 0, 0, 18);
        drain();
        check_output("all_released", direction, 4'b0000);

        $display("[TB] space, keypad, parity, stop");
        apply_stimulus(8'h29, 0, 0, 22);
        drain();
        check_output("fire_on", fire, 1);
        apply_stimulus(8'hF0, 0, 0, 22);
        apply_stimulus(8'h29, 0, 0, 22);
        apply_stimulus(8'h75, 0, 0, 22);
        drain();
        check_output("fire_off", fire, 0);
        check_output("keypad_ignored", direction, 4'b0000);
        apply_stimulus(8'hE0, 0, 0, 22);
        apply_stimulus(8'h75, 1, 0, 22);
        apply_stimulus(8'h72, 0, 1, 22);
        drain();

        $display("[TB] stalled frame");
        drive_bit(1'b0, 20);
        for (int i = 0; i < 4; i++) drive_bit(1'(i & 1), 20);
        ps2_data = 1'b1;
        e = '{is_err: 1, code: 8'h00, dir: 4'b0, fire: 1'b0, chk_time: 1,
              lo: last_fall + FILTER_LEN + TIMEOUT, hi: last_fall + FILTER_LEN + TIMEOUT + 4};
        exp_q.push_back(e);
        repeat (TIMEOUT + 40) @(negedge clk);
        drain();
        apply_stimulus(8'hE0, 0, 0, 20);
        apply_stimulus(8'h72, 0, 0, 20);
        drain();
        check_output("down_after_timeout", direction, model_dir());

        $display("[TB] reset mid-frame");
        drive_bit(1'b0, 20);
        for (int i = 0; i < 3; i++) drive_bit(1'b1, 20);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_output("midreset_direction", direction, 0);
        check_output("midreset_fire", fire, 0);
        check_output("midreset_code", code, 0);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        apply_stimulus(8'hE0, 0, 0, 20);
        apply_stimulus(8'h74, 0, 0, 20);
        drain();
        check_output("right_after_reset", direction, 4'b1000);

        $display("[TB] random traffic");
        for (int n = 0; n < 50; n++) begin
            if ($urandom_range(0, 7) == 7) b = 8'($urandom);
            else b = picks[$urandom_range(0, 6)];
            apply_stimulus(b, $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0, $urandom_range(15, 30));
        end
        drain();
        check_output("final_direction", direction, model_dir());
        check_output("final_fire", fire, m_fire);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
